// File: rtl/rs_syndrome_calc_if.sv
// rtl/rs_syndrome_calc_if.sv - symbol stream in, packed syndromes out for rs_syndrome_calc
interface rs_syndrome_calc_if #(
    parameter int NSYM = 16
) ();
    logic [7:0]        din;
    logic              din_valid;
    logic              frame_start;
    logic [8*NSYM-1:0] syn_out;
    logic              syn_valid;
    logic              err_flag;
    logic              frame_err;

    modport master (
        output din, din_valid, frame_start,
        input  syn_out, syn_valid, err_flag, frame_err
    );

    modport slave (
        input  din, din_valid, frame_start,
        output syn_out, syn_valid, err_flag, frame_err
    );
endinterface

// File: rtl/rs_syndrome_calc.sv
// rtl/rs_syndrome_calc.sv - RS(255,239) syndrome calculator with parallel Horner accumulators
module rs_syndrome_calc #(
    parameter int         N         = 255,
    parameter int         K         = 239,
    parameter int         FCR       = 0,
    parameter logic [8:0] PRIM_POLY = 9'h11D,
    localparam int        NSYM      = N - K
) (
    input  logic                clk,
    input  logic                rst,
    rs_syndrome_calc_if.slave   bus
);

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? PRIM_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < e; i++) v = xtime(v);
        return v;
    endfunction

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NSYM-1:0][7:0]    acc_q, acc_d, mul;
    logic [NSYM-1:0][7:0]    syn_q;
    logic                    syn_valid_q, err_flag_q, frame_err_q;
    logic                    load, step, last, restart;

    // Root multiplier constants are folded at elaboration; each gf_mul reduces to an XOR network.
    for (genvar j = 0; j < NSYM; j++) begin : g_root
        localparam logic [7:0] ROOT = alpha_pow((FCR + j) % 255);
        assign mul[j] = gf_mul(acc_q[j], ROOT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.din_valid && bus.frame_start) state_d = ACCUM;
            ACCUM:   if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load    = bus.din_valid && bus.frame_start;
        step    = (state_q == ACCUM) && bus.din_valid && !bus.frame_start;
        last    = step && (cnt_q == 8'(N - 1));
        restart = (state_q == ACCUM) && bus.din_valid && bus.frame_start && (cnt_q != 8'(N));
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (load) begin
            cnt_d = 8'd1;
            for (int j = 0; j < NSYM; j++) acc_d[j] = bus.din;
        end else if (step) begin
            cnt_d = last ? 8'd0 : cnt_q + 8'd1;
            for (int j = 0; j < NSYM; j++) acc_d[j] = mul[j] ^ bus.din;
        end
    end

    // syn_q is separate from acc_q so a back-to-back frame cannot disturb the reported result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 8'd0;
            acc_q       <= '0;
            syn_q       <= '0;
            err_flag_q  <= 1'b0;
            syn_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            syn_valid_q <= last;
            frame_err_q <= restart;
            if (last) begin
                syn_q      <= acc_d;
                err_flag_q <= |acc_d;
            end
        end
    end

    assign bus.syn_out   = syn_q;
    assign bus.syn_valid = syn_valid_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.frame_err = frame_err_q;

endmodule
